// File: rtl/race_status_display.sv
// Race status decoder: keeps the SS.cc race timer and drives the 4-digit
// multiplexed 7-segment display from the registered game state.
module race_status_display #(
   parameter int unsigned TICK_DIV  = 1_000_000,
   parameter int unsigned SCAN_DIV  = 100_000,
   parameter int unsigned BLINK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  state,
   input  logic [1:0]  countdown_val,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [15:0] time_bcd,
   output logic        time_valid,
   output logic        overflow,
   output logic        illegal_state
);

   localparam int unsigned TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SETTING   = 3'd1;
   localparam logic [2:0] S_COUNTDOWN = 3'd3;
   localparam logic [2:0] S_RACING    = 3'd4;
   localparam logic [2:0] S_PAUSE     = 3'd5;
   localparam logic [2:0] S_FINISH    = 3'd6;

   localparam logic [6:0] G_DASH  = 7'b0111111;
   localparam logic [6:0] G_BLANK = 7'h7F;
   localparam logic [6:0] G_E     = 7'b0000110;
   localparam logic [6:0] G_T     = 7'b0000111;
   localparam logic [6:0] G_S     = 7'b0010010;

   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      case (d)
         4'd0: digit_glyph = 7'b1000000;
         4'd1: digit_glyph = 7'b1111001;
         4'd2: digit_glyph = 7'b0100100;
         4'd3: digit_glyph = 7'b0110000;
         4'd4: digit_glyph = 7'b0011001;
         4'd5: digit_glyph = 7'b0010010;
         4'd6: digit_glyph = 7'b0000010;
         4'd7: digit_glyph = 7'b1111000;
         4'd8: digit_glyph = 7'b0000000;
         4'd9: digit_glyph = 7'b0010000;
         default: digit_glyph = G_BLANK;
      endcase
   endfunction

   // Four-digit BCD increment with ripple carry; caller handles 99.99.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic [2:0]         st_q, st_prev;
   logic [1:0]         cd_q;
   logic [TICK_W-1:0]  tick_cnt, tick_base;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_on;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         scan_idx;
   logic               entry, clear_time, racing, tick, show_on;
   logic [3:0]         nib;
   logic [6:0]         seg_c;
   logic               dp_c;

   always_comb begin
      entry      = (st_q != st_prev);
      clear_time = entry && ((st_q == S_IDLE) || (st_q == S_COUNTDOWN));
      racing     = (st_q == S_RACING);
      tick_base  = (entry && (st_prev == S_COUNTDOWN)) ? '0 : tick_cnt;
      tick       = racing && (tick_base == TICK_W'(TICK_DIV - 1));
      show_on    = blink_on || (entry && (st_q == S_PAUSE));
   end

   // Input capture; status flags decode the same registered state.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q          <= S_IDLE;
         st_prev       <= S_IDLE;
         cd_q          <= 2'd0;
         time_valid    <= 1'b0;
         illegal_state <= 1'b0;
      end else begin
         st_q          <= state;
         st_prev       <= st_q;
         cd_q          <= countdown_val;
         time_valid    <= (state == S_FINISH);
         illegal_state <= (state == 3'd2) || (state == 3'd7);
      end
   end

   // Race timer: prescaler runs only while racing, saturates at 99.99.
   always_ff @(posedge clk) begin
      if (rst || clear_time) begin
         tick_cnt <= '0;
         time_bcd <= 16'h0000;
         overflow <= 1'b0;
      end else if (racing) begin
         tick_cnt <= tick ? '0 : tick_base + TICK_W'(1);
         if (tick) begin
            if (time_bcd == 16'h9999) overflow <= 1'b1;
            else                      time_bcd <= bcd_inc(time_bcd);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (st_q == S_PAUSE) begin
         if (entry) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= 2'd0;
      end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Glyph selection for the digit currently being scanned.
   always_comb begin
      seg_c = G_BLANK;
      dp_c  = 1'b1;
      case (scan_idx)
         2'd0:    nib = time_bcd[3:0];
         2'd1:    nib = time_bcd[7:4];
         2'd2:    nib = time_bcd[11:8];
         default: nib = time_bcd[15:12];
      endcase
      case (st_q)
         S_IDLE: seg_c = G_DASH;
         S_SETTING: begin
            case (scan_idx)
               2'd3:    seg_c = G_S;
               2'd2:    seg_c = G_E;
               2'd1:    seg_c = G_T;
               default: seg_c = G_DASH;
            endcase
         end
         S_COUNTDOWN: if (scan_idx == 2'd0) seg_c = digit_glyph({2'b00, cd_q});
         S_RACING, S_FINISH: begin
            seg_c = digit_glyph(nib);
            dp_c  = (scan_idx != 2'd2);
         end
         S_PAUSE: begin
            if (show_on) begin
               seg_c = digit_glyph(nib);
               dp_c  = (scan_idx != 2'd2);
            end
         end
         default: seg_c = (scan_idx == 2'd3) ? G_E : G_DASH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= G_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << scan_idx);
         seg <= seg_c;
         dp  <= dp_c;
      end
   end

endmodule

// File: tb/tb_race_status_display.sv
// Bench for race_status_display: directed table, hand sequences and random
// state traffic checked every cycle against an elapsed-cycle reference model.
module tb_race_status_display;

   localparam int TICK  = 4;
   localparam int SCAN  = 2;
   localparam int BLINK = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  state;
   logic [1:0]  countdown_val;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [15:0] time_bcd;
   logic        time_valid, overflow, illegal_state;

   race_status_display #(.TICK_DIV(TICK), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
      .clk(clk), .rst(rst), .state(state), .countdown_val(countdown_val),
      .an(an), .seg(seg), .dp(dp), .time_bcd(time_bcd), .time_valid(time_valid),
      .overflow(overflow), .illegal_state(illegal_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [6:0] glyph [10];
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'h7F;
   localparam logic [6:0] GE    = 7'b0000110;
   localparam logic [6:0] GT    = 7'b0000111;

   // Reference model: registered state, racing cycles since last clear,
   // consecutive PAUSE cycles, and cycles since reset.
   int m_st, m_prev, m_cd, m_race, m_pc, m_e;

   function automatic logic [15:0] to_bcd(input int t);
      return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
   endfunction

   function automatic logic [7:0] exp_disp(input int st, input int cd, input int t,
                                           input bit on, input int idx);
      int dig[4];
      logic [6:0] s;
      logic d;
      s = BLANK;
      d = 1'b1;
      dig[0] = t % 10;
      dig[1] = (t / 10) % 10;
      dig[2] = (t / 100) % 10;
      dig[3] = t / 1000;
      case (st)
         0: s = DASH;
         1: s = (idx == 3) ? glyph[5] : (idx == 2) ? GE : (idx == 1) ? GT : DASH;
         3: if (idx == 0) s = glyph[cd];
         4, 6: begin s = glyph[dig[idx]]; d = (idx != 2); end
         5: if (on) begin s = glyph[dig[idx]]; d = (idx != 2); end
         default: s = (idx == 3) ? GE : DASH;
      endcase
      return {s, d};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, got, exp);
      end
   endtask

   // One clock: predict from model, advance model with current inputs, compare.
   task automatic step();
      int t_pre, idx, tk;
      bit on;
      logic [3:0] e_an;
      logic [7:0] e_sd;
      if (rst) begin
         m_st = 0; m_prev = 0; m_cd = 0; m_race = 0; m_pc = 0; m_e = 0;
         e_an = 4'hF;
         e_sd = {BLANK, 1'b1};
      end else begin
         t_pre = m_race / TICK;
         if (t_pre > 9999) t_pre = 9999;
         idx  = (m_e / SCAN) % 4;
         on   = (m_pc == 0) || ((((m_pc - 1) / BLINK) % 2) == 0);
         e_sd = exp_disp(m_st, m_cd, t_pre, on, idx);
         e_an = ~4'(1 << idx);
         if (m_st != m_prev && (m_st == 0 || m_st == 3)) m_race = 0;
         else if (m_st == 4) m_race++;
         m_pc   = (m_st == 5) ? m_pc + 1 : 0;
         m_prev = m_st;
         m_st   = int'(state);
         m_cd   = int'(countdown_val);
         m_e++;
      end
      @(posedge clk);
      #1;
      cyc++;
      tk = m_race / TICK;
      check("display", {20'd0, an, seg, dp}, {20'd0, e_an, e_sd});
      check("timer", {15'd0, overflow, time_bcd},
            {15'd0, (tk >= 10000), to_bcd(tk > 9999 ? 9999 : tk)});
      check("status", {30'd0, time_valid, illegal_state},
            {30'd0, (m_st == 6), (m_st == 2 || m_st == 7)});
   endtask

   task automatic hold(input int st, input int cd, input int n);
      state = 3'(st);
      countdown_val = 2'(cd);
      repeat (n) step();
   endtask

   typedef struct {
      int          st;
      int          cd;
      int          n;
      logic [15:0] t;
      logic        ovf;
      logic        valid;
      logic        ill;
      bit          chk0;
      logic [6:0]  seg0;
   } vec_t;

   vec_t tbl [19];

   initial begin
      int blank_seen, lit_seen;
      bit found;

      glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
      glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
      glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
      glyph[9] = 7'b0010000;

      tbl[0]  = '{0, 0, 8,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0111111};
      tbl[1]  = '{3, 3, 6,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0110000};
      tbl[2]  = '{3, 2, 6,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0100100};
      tbl[3]  = '{3, 1, 6,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1111001};
      tbl[4]  = '{4, 0, 401,   16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[5]  = '{5, 0, 50,    16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[6]  = '{3, 0, 4,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000};
      tbl[7]  = '{4, 0, 10,    16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[8]  = '{5, 0, 50,    16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[9]  = '{4, 0, 6,     16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[10] = '{6, 0, 4,     16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
      tbl[11] = '{7, 0, 4,     16'h0004, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0111111};
      tbl[12] = '{6, 0, 3,     16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
      tbl[13] = '{3, 0, 3,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[14] = '{4, 0, 39993, 16'h9998, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[15] = '{4, 0, 32,    16'h9999, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[16] = '{3, 0, 3,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
      tbl[17] = '{1, 0, 4,     16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0111111};
      tbl[18] = '{2, 0, 4,     16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0111111};

      rst = 1'b1;
      state = 3'd0;
      countdown_val = 2'd0;
      repeat (2) step();
      check("rst_an", 32'(an), 32'h0000000F);
      check("rst_seg_dp", {24'd0, seg, dp}, {24'd0, 7'h7F, 1'b1});
      check("rst_timer", {14'd0, time_valid, overflow, time_bcd}, 32'd0);
      check("rst_illegal", 32'(illegal_state), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         hold(tbl[i].st, tbl[i].cd, tbl[i].n);
         check("tbl_time", {15'd0, tbl[i].ovf, tbl[i].t}, {15'd0, overflow, time_bcd});
         check("tbl_flags", {30'd0, time_valid, illegal_state},
               {30'd0, tbl[i].valid, tbl[i].ill});
         if (tbl[i].chk0) begin
            found = 1'b0;
            for (int k = 0; k < 8 && !found; k++) begin
               step();
               if (an == 4'b1110) found = 1'b1;
            end
            check("tbl_digit0_seen", 32'(found), 32'd1);
            if (found) check("tbl_digit0_seg", 32'(seg), 32'(tbl[i].seg0));
         end
      end

      // PAUSE must alternate between lit and blank display.
      hold(3, 0, 3);
      hold(4, 0, 5);
      state = 3'd5;
      blank_seen = 0;
      lit_seen   = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (an != 4'hF && seg == 7'h7F && dp == 1'b1) blank_seen++;
         else if (seg != 7'h7F) lit_seen++;
      end
      check("pause_blank_seen", 32'(blank_seen > 0), 32'd1);
      check("pause_lit_seen", 32'(lit_seen > 0), 32'd1);

      // Reset in the middle of a race.
      hold(4, 0, 20);
      rst = 1'b1;
      step();
      check("midrace_rst_disp", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
      check("midrace_rst_timer", {15'd0, overflow, time_bcd}, 32'd0);
      rst = 1'b0;

      for (int s = 0; s < 300; s++) begin
         rst = ($urandom_range(0, 49) == 0);
         hold(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 40)));
      end
      rst = 1'b0;
      hold(0, 0, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
